// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Line geometry and Sysbus request tag fields live here so every fetch file agrees on them.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RECV,
      DRAIN,
      HALT
   } fsm_state_t;

   localparam int LINE_BEATS = 8;
   localparam int LINE_SLOTS = 2 * LINE_BEATS;

   // Sysbus tag fields: direction bit, target class, then an 8-bit id.
   localparam logic       SYSBUS_READ   = 1'b1;
   localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
   localparam logic [12:0] FETCH_REQ_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

endpackage

// File: rtl/inst_line_buffer.sv
// One cache line of response beats; written a beat at a time, read a 32-bit slot at a time.
// Write takes effect on the next edge; the slot read is purely combinational.
module inst_line_buffer #(
   parameter int DATA_WIDTH = 64,
   parameter int BEATS      = 8,
   localparam int BEAT_BITS = $clog2(BEATS),
   localparam int SLOT_BITS = $clog2(2 * BEATS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [BEAT_BITS-1:0]    beat_idx_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   input  logic [SLOT_BITS-1:0]    slot_i,
   output logic [DATA_WIDTH/2-1:0] word_o
);

   logic [DATA_WIDTH-1:0] mem_q [BEATS];
   logic [BEAT_BITS-1:0]  rd_beat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BEATS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[beat_idx_i] <= data_i;
      end
   end

   // Even slots are the low half of a beat, odd slots the high half.
   assign rd_beat = slot_i[SLOT_BITS-1:1];

   always_comb begin
      word_o = mem_q[rd_beat][DATA_WIDTH/2-1:0];
      if (slot_i[0]) begin
         word_o = mem_q[rd_beat][DATA_WIDTH-1:DATA_WIDTH/2];
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches 64-byte lines over Sysbus, then hands their 32-bit words to the decoder one per handshake.
// No prefetch: the next line is requested only after the current one drains; a zero word halts for good.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [BUS_DATA_WIDTH-1:0]   entry,
   output logic                        bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0]   bus_req,
   output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
   input  logic                        bus_reqack,
   input  logic                        bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
   output logic                        bus_respack,
   output logic                        inst_valid,
   output logic [BUS_DATA_WIDTH/2-1:0] inst,
   output logic [BUS_DATA_WIDTH-1:0]   inst_pc,
   input  logic                        inst_ready,
   output logic                        halted
);

   localparam int BEAT_BITS   = $clog2(LINE_BEATS);
   localparam int SLOT_BITS   = $clog2(LINE_SLOTS);
   localparam int OFFSET_BITS = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 8);

   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);
   localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(LINE_SLOTS - 1);

   fsm_state_t                state_q, state_d;
   logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
   logic [BEAT_BITS-1:0]      beat_cnt_q, beat_cnt_d;
   logic [SLOT_BITS-1:0]      slot_q, slot_d;

   logic                        buf_we;
   logic [BUS_DATA_WIDTH/2-1:0] slot_word;
   logic                        slot_is_zero;

   inst_line_buffer #(
      .DATA_WIDTH (BUS_DATA_WIDTH),
      .BEATS      (LINE_BEATS)
   ) u_line_buffer (
      .clk        (clk),
      .rst        (reset),
      .we_i       (buf_we),
      .beat_idx_i (beat_cnt_q),
      .data_i     (bus_resp),
      .slot_i     (slot_q),
      .word_o     (slot_word)
   );

   assign slot_is_zero = (slot_word == '0);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      beat_cnt_d = beat_cnt_q;
      slot_d     = slot_q;
      buf_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               pc_d    = entry;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus_reqack) begin
               beat_cnt_d = '0;
               // Mid-line entry: draining begins at the entry word, not slot 0.
               slot_d     = pc_q[OFFSET_BITS-1:2];
               state_d    = RECV;
            end
         end
         RECV: begin
            if (bus_respcyc) begin
               buf_we     = 1'b1;
               beat_cnt_d = beat_cnt_q + BEAT_BITS'(1);
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (slot_is_zero) begin
               state_d = HALT;
            end else if (inst_ready) begin
               pc_d   = pc_q + BUS_DATA_WIDTH'(4);
               slot_d = slot_q + SLOT_BITS'(1);
               if (slot_q == LAST_SLOT) begin
                  state_d = REQ;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         beat_cnt_q <= '0;
         slot_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         beat_cnt_q <= beat_cnt_d;
         slot_q     <= slot_d;
      end
   end

   assign bus_reqcyc  = (state_q == REQ);
   assign bus_req     = bus_reqcyc ? {pc_q[BUS_DATA_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
   assign bus_reqtag  = bus_reqcyc ? BUS_TAG_WIDTH'(FETCH_REQ_TAG) : '0;
   assign bus_respack = (state_q == RECV) && bus_respcyc;

   assign inst_valid  = (state_q == DRAIN) && !slot_is_zero;
   assign inst        = inst_valid ? slot_word : '0;
   assign inst_pc     = inst_valid ? pc_q : '0;
   assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a bus model serves lines whose words derive from their
// address, and a scoreboard queue holds the instructions the decoder side must see, in order.
module tb_fetch_sequencer;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] entry = '0;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack = 1'b0;
   logic        bus_respcyc = 1'b0;
   logic [63:0] bus_resp = '0;
   logic        bus_respack;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        halted;

   int          n_checks = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   logic [63:0] zero_addr = '1;
   exp_t        exp_q [$];

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .entry       (entry),
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_respack (bus_respack),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == zero_addr) return 32'h0;
      return 32'hC0DE_0000 ^ a[31:0];
   endfunction

   function automatic logic [63:0] beat_data(input logic [63:0] line, input int b);
      logic [63:0] a;
      a = line + 64'(8 * b);
      return {mem_word(a + 64'd4), mem_word(a)};
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      start       = 1'b0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      inst_ready  = 1'b0;
      zero_addr   = '1;
      exp_q.delete();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic pulse_start(input logic [63:0] e);
      entry = e;
      start = 1'b1;
      step();
      start = 1'b0;
      check("req_after_start", bus_reqcyc, 1);
   endtask

   task automatic serve_request(input logic [63:0] exp_addr, input int ack_delay);
      int t = 0;
      while (!bus_reqcyc && t < 50) begin
         step();
         t++;
      end
      check("req_vld", bus_reqcyc, 1);
      check("req_addr", bus_req, exp_addr);
      check("req_tag", bus_reqtag, 64'h1100);
      for (int i = 0; i < ack_delay; i++) begin
         step();
         check("req_hold", bus_req, exp_addr);
      end
      bus_reqack = 1'b1;
      step();
      bus_reqack = 1'b0;
      check("req_drop", bus_reqcyc, 0);
   endtask

   task automatic send_beats(input logic [63:0] line, input int nbeats, input int gap);
      for (int b = 0; b < nbeats; b++) begin
         bus_respcyc = 1'b1;
         bus_resp    = beat_data(line, b);
         #1;
         check("respack", bus_respack, 1);
         step();
         bus_respcyc = 1'b0;
         bus_resp    = '0;
         if (b != nbeats - 1) begin
            for (int g = 0; g < gap; g++) step();
         end
      end
   endtask

   task automatic push_line(input logic [63:0] start_pc);
      logic [63:0] a;
      logic [63:0] line_end;
      exp_t        e;
      line_end = {start_pc[63:6], 6'b0} + 64'd64;
      a = start_pc;
      while (a != line_end && mem_word(a) != 32'h0) begin
         e.pc   = a;
         e.word = mem_word(a);
         exp_q.push_back(e);
         a = a + 64'd4;
      end
   endtask

   // With stall set, inst_ready follows the repeating pattern 1,0,0,1.
   task automatic drain(input bit stall);
      int t = 0;
      int ph = 0;
      while (exp_q.size() != 0 && t < 200) begin
         inst_ready = stall ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
         #1;
         if (inst_valid) begin
            check("inst", inst, exp_q[0].word);
            check("inst_pc", inst_pc, exp_q[0].pc);
            if (inst_ready) void'(exp_q.pop_front());
         end
         ph++;
         step();
         t++;
      end
      inst_ready = 1'b0;
      check("drain_done", 64'(exp_q.size()), 0);
   endtask

   initial begin
      logic [63:0] beat;

      #3;
      check("rst_reqcyc", bus_reqcyc, 0);
      check("rst_req", bus_req, 0);
      check("rst_reqtag", bus_reqtag, 0);
      check("rst_respack", bus_respack, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_halted", halted, 0);
      step();
      reset = 1'b0;
      step();

      // Aligned fetch with the decoder always ready.
      pulse_start(64'h1000);
      serve_request(64'h1000, 0);
      send_beats(64'h1000, 8, 0);
      check("first_inst_vld", inst_valid, 1);
      push_line(64'h1000);
      check("line_len", 64'(exp_q.size()), 16);
      drain(1'b0);
      check("next_req_vld", bus_reqcyc, 1);
      check("next_req_addr", bus_req, 64'h1040);

      // Second line: slow acknowledge, gapped beats, decoder backpressure.
      serve_request(64'h1040, 3);
      send_beats(64'h1040, 8, 2);
      check("slow_first_vld", inst_valid, 1);
      push_line(64'h1040);
      drain(1'b1);
      check("third_req_vld", bus_reqcyc, 1);
      check("third_req_addr", bus_req, 64'h1080);

      // Mid-line entry.
      do_reset();
      pulse_start(64'h1008);
      serve_request(64'h1000, 0);
      send_beats(64'h1000, 8, 0);
      beat = beat_data(64'h1000, 1);
      check("mid_first_pc", inst_pc, 64'h1008);
      check("mid_first_inst", inst, beat[31:0]);
      push_line(64'h1008);
      check("mid_line_len", 64'(exp_q.size()), 14);
      drain(1'b0);

      // Zero word in slot 5 halts the block.
      do_reset();
      zero_addr = 64'h3014;
      pulse_start(64'h3000);
      serve_request(64'h3000, 0);
      send_beats(64'h3000, 8, 0);
      push_line(64'h3000);
      check("zero_presented_cnt", 64'(exp_q.size()), 5);
      drain(1'b0);
      check("zero_not_presented", inst_valid, 0);
      check("halt_not_yet", halted, 0);
      step();
      check("halted", halted, 1);
      check("halt_inst_valid", inst_valid, 0);
      check("halt_reqcyc", bus_reqcyc, 0);
      entry = 64'h1000;
      start = 1'b1;
      step();
      start = 1'b0;
      bus_respcyc = 1'b1;
      step();
      check("halt_ignore_start", bus_reqcyc, 0);
      check("halt_respack", bus_respack, 0);
      check("halt_sticky", halted, 1);
      bus_respcyc = 1'b0;

      // Reset in the middle of a burst.
      do_reset();
      pulse_start(64'h1000);
      serve_request(64'h1000, 0);
      send_beats(64'h1000, 4, 0);
      bus_respcyc = 1'b1;
      bus_resp    = beat_data(64'h1000, 4);
      #1;
      reset = 1'b1;
      #1;
      check("arst_respack", bus_respack, 0);
      check("arst_reqcyc", bus_reqcyc, 0);
      check("arst_inst_valid", inst_valid, 0);
      check("arst_halted", halted, 0);
      step();
      reset = 1'b0;
      for (int b = 5; b < 8; b++) begin
         bus_resp = beat_data(64'h1000, b);
         step();
         check("idle_drop_beat", bus_respack, 0);
      end
      bus_respcyc = 1'b0;
      pulse_start(64'h2000);
      serve_request(64'h2000, 0);
      send_beats(64'h2000, 8, 0);
      push_line(64'h2000);
      drain(1'b0);
      check("after_rst_next_req", bus_req, 64'h2040);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer between the system bus and the instruction decoder. It requests 64-byte instruction lines over the Sysbus and captures the eight 64-bit response beats into a line buffer. It then presents the line's 32-bit instructions one per handshake to the decoder stage, advances through memory line by line, and halts on an all-zero instruction word.

## Interface
- BUS_DATA_WIDTH, 64, Sysbus data/address width
- BUS_TAG_WIDTH, 13, Sysbus tag width
- LINE_BEATS, 8, response beats per line (line = LINE_BEATS*8 bytes)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begin fetching at entry (ignored unless IDLE)
- entry  in  BUS_DATA_WIDTH  first PC; must be 4-byte aligned
- bus_reqcyc  out  1  request valid
- bus_req  out  BUS_DATA_WIDTH  line address
- bus_reqtag  out  BUS_TAG_WIDTH  {`SYSBUS_READ, `SYSBUS_MEMORY, 8'h00}
- bus_reqack  in  1  request accepted
- bus_respcyc  in  1  response beat valid
- bus_resp  in  BUS_DATA_WIDTH  response beat data
- bus_respack  out  1  beat accepted
- inst_valid  out  1  instruction presented to decoder
- inst  out  BUS_DATA_WIDTH/2  instruction word
- inst_pc  out  BUS_DATA_WIDTH  address of inst
- inst_ready  in  1  decoder accepts inst
- halted  out  1  sticky; zero instruction reached

## Operation
- States: IDLE, REQ, RECV, DRAIN, HALT. Reset state is IDLE.
- IDLE: on start, pc <= entry; go to REQ.
- REQ:
  - bus_reqcyc=1, bus_req = pc with bits [5:0] cleared.
  - Hold the request stable until bus_reqack; on ack go to RECV and clear beat_cnt.
- RECV:
  - bus_respack = bus_respcyc (combinational; no backpressure).
  - Each beat is written to buffer[beat_cnt], and beat_cnt increments.
  - After beat LINE_BEATS-1, go to DRAIN. Slot index starts at pc[5:2].
- DRAIN:
  - Slot s maps to beat s>>1; even slot = bits [31:0], odd slot = bits [63:32].
  - inst_valid=1, inst = slot word, inst_pc = pc.
  - On inst_valid && inst_ready: pc += 4 and the slot advances.
  - If the accepted slot was 15, go to REQ for the next line; pc is now line-aligned.
- Zero word: if the current slot word is 32'h0, inst_valid stays 0 and the block goes to HALT. The zero word is never presented.
- HALT: halted=1. All bus and inst outputs are 0. Only reset leaves HALT.
- start outside IDLE: no effect.
- Beats while not in RECV: bus_respack=0 and the data is dropped.
- Mid-line entry: slots below pc[5:2] are never presented.
- Reset mid-burst: the block returns to IDLE immediately and the rest of the burst is ignored.
- pc wraps modulo 2^BUS_DATA_WIDTH with no error.

## Timing
- Reset values: bus_reqcyc=0, bus_req=0, bus_reqtag=0, bus_respack=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
- Request launch: bus_reqcyc rises the cycle after start; it rises the cycle after the slot-15 handshake.
- inst_valid rises the cycle after the last beat is captured. The first instruction therefore appears the cycle after beat LINE_BEATS-1.
- Throughput in DRAIN: one instruction per cycle while inst_ready=1.
- Stability: inst and inst_pc stay stable while inst_valid && !inst_ready.
- No prefetch: the next line request issues only after the current line fully drains.
- Request tag: bus_reqtag is valid only while bus_reqcyc=1 and is 0 otherwise.
- halted is registered; it asserts the cycle after the zero word reaches the output slot.

## Structure
- fsm_state_t enum and LINE_SLOTS (=2*LINE_BEATS) go in shared package fetch_pkg. Tag fields come from Sysbus.defs.
- Sub-module inst_line_buffer:
  - LINE_BEATS x 64 storage, write port (we, beat index, data).
  - Read port: slot index in, 32-bit word out, selected combinationally.
- Top level holds the FSM, pc, beat_cnt and slot pointer.

## Test plan
- Aligned fetch: entry=0x1000, memory model returns 8 beats holding 16 nonzero words, inst_ready=1.
  - Expect bus_req=0x1000 and tag={READ,MEMORY,0}.
  - Expect 16 instructions with inst_pc 0x1000..0x103C in order, low half of each beat first.
  - Then expect a second request at 0x1040.
- Mid-line entry: entry=0x1008. Expect request 0x1000; the first inst_pc is 0x1008 with inst = beat1[31:0].
- Backpressure: inst_ready toggles 1,0,0,1. Expect inst and inst_pc to hold through the stalls, with no skipped or repeated pc.
- Zero halt: slot 5 holds 0x00000000.
  - Expect 5 instructions presented, then halted=1 the following cycle.
  - Expect no further bus_reqcyc, and later start pulses to be ignored.
- Slow bus: bus_reqack delayed 3 cycles and beats spaced with idle gaps. Expect bus_req held stable and correct capture of all 8 beats.
- Reset mid-burst: assert reset after beat 3. Expect all outputs at reset values asynchronously. After start with entry=0x2000, expect a clean request at 0x2000.
